// File: rtl/shared_net_monitor.sv
// shared_net_monitor
//   Reader side of a multi-driver shared net. Samples the enable/value pairs
//   of N_DRV drivers, resolves the net with wire semantics (undriven -> Z,
//   agreement -> value, disagreement -> X), filters contention over FILT
//   consecutive cycles and keeps a sticky flag plus a saturating event count.
//   All outputs are registered (one cycle of latency).
//
//   Optional feature macro: NET_MON_KEEPER_EN
//     defined   : bus-keeper; res_val in FLOAT holds the last DRIVEN value
//     undefined : res_val is 0 in FLOAT
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset
//   drv_en      per-driver enable (bit i = driver i is driving)
//   drv_val     per-driver value, ignored where drv_en is 0
//   clr         synchronous clear of cont_sticky and cont_cnt
//   res_val     resolved net value
//   res_z       net undriven
//   res_x       net in filtered contention
//   cont_sticky set on a contention event, held until clr
//   cont_cnt    saturating count of contention events
//   state       FSM state: 0 FLOAT, 1 DRIVEN, 2 SUSPECT, 3 CONTEND
module shared_net_monitor #(
  parameter int unsigned N_DRV = 4,
  parameter int unsigned FILT  = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DRV-1:0] drv_en,
  input  logic [N_DRV-1:0] drv_val,
  input  logic             clr,
  output logic             res_val,
  output logic             res_z,
  output logic             res_x,
  output logic             cont_sticky,
  output logic [CNT_W-1:0] cont_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    FLOAT   = 2'd0,
    DRIVEN  = 2'd1,
    SUSPECT = 2'd2,
    CONTEND = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_n;
  logic [3:0] filt_q;
  logic [3:0] filt_n;
  logic [4:0] filt_inc;

  logic any1;
  logic any0;
  logic none;
  logic conflict;
  logic cont_event;

`ifdef NET_MON_KEEPER_EN
  logic keep_q;
`endif

  // Per-cycle classification; disabled drivers are masked out entirely.
  assign any1     = |(drv_en & drv_val);
  assign any0     = |(drv_en & ~drv_val);
  assign none     = ~|drv_en;
  assign conflict = any1 & any0;
  assign filt_inc = {1'b0, filt_q} + 5'd1;

  always_comb begin
    state_n = state_q;
    filt_n  = filt_q;
    unique case (state_q)
      FLOAT, DRIVEN: begin
        if (conflict) begin
          if (FILT <= 1) begin
            state_n = CONTEND;
            filt_n  = '0;
          end else begin
            state_n = SUSPECT;
            filt_n  = 4'd1;
          end
        end else begin
          state_n = none ? FLOAT : DRIVEN;
          filt_n  = '0;
        end
      end
      SUSPECT: begin
        if (conflict) begin
          if (filt_inc >= 5'(FILT)) begin
            state_n = CONTEND;
            filt_n  = '0;
          end else begin
            state_n = SUSPECT;
            filt_n  = filt_inc[3:0];
          end
        end else begin
          state_n = none ? FLOAT : DRIVEN;
          filt_n  = '0;
        end
      end
      CONTEND: begin
        if (conflict) begin
          state_n = CONTEND;
        end else begin
          state_n = none ? FLOAT : DRIVEN;
        end
        filt_n = '0;
      end
      default: begin
        state_n = FLOAT;
        filt_n  = '0;
      end
    endcase
  end

  // Only the entry into CONTEND counts as an event.
  assign cont_event = (state_n == CONTEND) && (state_q != CONTEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FLOAT;
      filt_q      <= '0;
      res_val     <= 1'b0;
      res_z       <= 1'b1;
      res_x       <= 1'b0;
      cont_sticky <= 1'b0;
      cont_cnt    <= '0;
`ifdef NET_MON_KEEPER_EN
      keep_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      filt_q  <= filt_n;
      res_z   <= (state_n == FLOAT);
      res_x   <= (state_n == CONTEND);

      unique case (state_n)
        DRIVEN: res_val <= any1;
`ifdef NET_MON_KEEPER_EN
        FLOAT:  res_val <= keep_q;
`else
        FLOAT:  res_val <= 1'b0;
`endif
        default: res_val <= res_val;
      endcase

`ifdef NET_MON_KEEPER_EN
      if (state_n == DRIVEN) begin
        keep_q <= any1;
      end
`endif

      // An event in the same cycle as clr wins: clear, then count it.
      if (cont_event) begin
        cont_sticky <= 1'b1;
        if (clr) begin
          cont_cnt <= CNT_W'(1);
        end else if (cont_cnt != '1) begin
          cont_cnt <= cont_cnt + CNT_W'(1);
        end
      end else if (clr) begin
        cont_sticky <= 1'b0;
        cont_cnt    <= '0;
      end
    end
  end

  assign state = state_q;

endmodule
